// File: rtl/trace_chk_pkg.sv
// Shared types and constants for the write-back trace checker.
// Golden entries are packed {pc, wnum, wdata}; the wdata field sits in the low bits.
package trace_chk_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DONE  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_MISMATCH  = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

  localparam int ENT_W         = 69;
  localparam int ENT_WDATA_LSB = 0;
  localparam int ENT_WNUM_LSB  = 32;
  localparam int ENT_PC_LSB    = 37;

  // Each register-file byte enable covers one byte of the write data.
  function automatic logic [31:0] we_mask(input logic [3:0] we);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{we[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_trace_checker_if.sv
// CPU debug write-back port plus the golden-trace valid/ready channel.
// master = CPU and golden source side, slave = trace checker.
interface wb_trace_checker_if;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        ref_valid;
  logic        ref_ready;
  logic [31:0] ref_pc;
  logic [4:0]  ref_wnum;
  logic [31:0] ref_wdata;

  modport master (
    output debug_wb_pc, debug_wb_rf_we,
    output debug_wb_rf_wnum, debug_wb_rf_wdata,
    output ref_valid, ref_pc, ref_wnum, ref_wdata,
    input  ref_ready
  );

  modport slave (
    input  debug_wb_pc, debug_wb_rf_we,
    input  debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  ref_valid, ref_pc, ref_wnum, ref_wdata,
    output ref_ready
  );
endinterface

// File: rtl/trace_sync_fifo.sv
// Single-clock FIFO holding golden trace entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module trace_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer advance; push and pop in one cycle both take effect.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wb_trace_checker.sv
// Checks each committed register write against the next golden entry.
// Latches the first failure and reports pass once the CPU reaches END_PC.
module wb_trace_checker
  import trace_chk_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] END_PC      = 32'h1c000100,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
  input  logic                clk,
  input  logic                resetn,
  wb_trace_checker_if.slave   tr,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [31:0]         err_pc,
  output logic [31:0]         err_exp_wdata,
  output logic [31:0]         err_got_wdata,
  output logic [31:0]         commit_cnt
);

  state_e           state;
  logic [15:0]      idle_cnt;
  logic [16:0]      idle_nx;
  logic             in_run;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             commit;
  logic             hit;
  logic             underflow;
  logic             mismatch;
  logic             timeout;
  logic             at_end;
  logic [ENT_W-1:0] head;
  logic [31:0]      head_pc;
  logic [4:0]       head_wnum;
  logic [31:0]      head_wdata;
  logic [31:0]      mask;
  logic [31:0]      got;

  assign in_run       = (state == ST_RUN);
  assign tr.ref_ready = resetn & in_run & ~full;
  assign push         = tr.ref_valid & tr.ref_ready;

  assign commit = in_run & (|tr.debug_wb_rf_we) &
                  (tr.debug_wb_rf_wnum != 5'd0);
  assign pop    = commit & ~empty;

  assign head_pc    = head[ENT_PC_LSB +: 32];
  assign head_wnum  = head[ENT_WNUM_LSB +: 5];
  assign head_wdata = head[ENT_WDATA_LSB +: 32];

  assign mask = we_mask(tr.debug_wb_rf_we);
  assign got  = tr.debug_wb_rf_wdata & mask;
  assign hit  = (tr.debug_wb_pc == head_pc) &&
                (tr.debug_wb_rf_wnum == head_wnum) &&
                (got == (head_wdata & mask));

  assign underflow = commit & empty;
  assign mismatch  = pop & ~hit;
  assign idle_nx   = {1'b0, idle_cnt} + 17'd1;
  assign timeout   = in_run & ~commit &
                     (idle_nx >= {1'b0, TIMEOUT_CYC});
  assign at_end    = in_run & (tr.debug_wb_pc == END_PC);

  trace_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  ({tr.ref_pc, tr.ref_wnum, tr.ref_wdata}),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  // Run/done/error FSM; all status outputs freeze once terminal.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_RUN;
      idle_cnt      <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= ERR_NONE;
      err_pc        <= '0;
      err_exp_wdata <= '0;
      err_got_wdata <= '0;
      commit_cnt    <= '0;
    end else if (in_run) begin
      if (commit) begin
        idle_cnt <= '0;
      end else if (idle_cnt != 16'hffff) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
      if (pop && hit) begin
        commit_cnt <= commit_cnt + 32'd1;
      end
      if (underflow) begin
        state         <= ST_ERROR;
        error         <= 1'b1;
        err_code      <= ERR_UNDERFLOW;
        err_pc        <= tr.debug_wb_pc;
        err_exp_wdata <= '0;
        err_got_wdata <= got;
      end else if (mismatch) begin
        state         <= ST_ERROR;
        error         <= 1'b1;
        err_code      <= ERR_MISMATCH;
        err_pc        <= tr.debug_wb_pc;
        err_exp_wdata <= head_wdata;
        err_got_wdata <= got;
      end else if (timeout) begin
        state         <= ST_ERROR;
        error         <= 1'b1;
        err_code      <= ERR_TIMEOUT;
        err_pc        <= '0;
        err_exp_wdata <= '0;
        err_got_wdata <= '0;
      end else if (at_end) begin
        state <= ST_DONE;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed and random stimulus for the write-back trace checker.
// Expected values come from a queue-based model of the checking rules.
module tb_wb_trace_checker;

  localparam int          DEPTH = 8;
  localparam logic [31:0] ENDPC = 32'h1c000100;
  localparam int          TO    = 16;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wd;
  } ent_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [31:0] err_pc;
  logic [31:0] err_exp_wdata;
  logic [31:0] err_got_wdata;
  logic [31:0] commit_cnt;

  int total = 0;
  int bad = 0;

  ent_t        q[$];
  bit          m_done;
  bit          m_err;
  logic [1:0]  m_code;
  logic [31:0] m_pc;
  logic [31:0] m_exp;
  logic [31:0] m_got;
  logic [31:0] m_cnt;
  int          m_idle;

  wb_trace_checker_if tr();

  wb_trace_checker #(
    .FIFO_DEPTH  (DEPTH),
    .END_PC      (ENDPC),
    .TIMEOUT_CYC (16'(TO))
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .tr            (tr),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .err_pc        (err_pc),
    .err_exp_wdata (err_exp_wdata),
    .err_got_wdata (err_got_wdata),
    .commit_cnt    (commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".error"}, 32'(error), 32'(m_err));
    chk({tag, ".code"}, 32'(err_code), 32'(m_code));
    chk({tag, ".err_pc"}, err_pc, m_pc);
    chk({tag, ".err_exp"}, err_exp_wdata, m_exp);
    chk({tag, ".err_got"}, err_got_wdata, m_got);
    chk({tag, ".cnt"}, commit_cnt, m_cnt);
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] we);
    logic [31:0] m;
    m = 0;
    if (we[0]) m = m | 32'h0000_00ff;
    if (we[1]) m = m | 32'h0000_ff00;
    if (we[2]) m = m | 32'h00ff_0000;
    if (we[3]) m = m | 32'hff00_0000;
    return m;
  endfunction

  function automatic void set_err(input logic [1:0] c, input logic [31:0] p,
                                  input logic [31:0] e, input logic [31:0] g);
    m_err  = 1;
    m_code = c;
    m_pc   = p;
    m_exp  = e;
    m_got  = g;
  endfunction

  function automatic void model_clear();
    q.delete();
    m_done = 0;
    m_err  = 0;
    m_code = 0;
    m_pc   = 0;
    m_exp  = 0;
    m_got  = 0;
    m_cnt  = 0;
    m_idle = 0;
  endfunction

  function automatic ent_t mk(input logic [31:0] p, input logic [4:0] n,
                              input logic [31:0] d);
    ent_t e;
    e.pc = p;
    e.wnum = n;
    e.wd = d;
    return e;
  endfunction

  // One clock: drive at negedge, apply model rules, return at next negedge.
  task automatic cyc(input logic [31:0] pc, input logic [3:0] we,
                     input logic [4:0] wn, input logic [31:0] wd,
                     input bit v, input ent_t e);
    bit          run;
    bit          rdy;
    bit          evt;
    logic [31:0] msk;
    logic [31:0] got;
    ent_t        h;
    run = !m_done && !m_err;
    rdy = run && (q.size() < DEPTH);
    tr.debug_wb_pc       = pc;
    tr.debug_wb_rf_we    = we;
    tr.debug_wb_rf_wnum  = wn;
    tr.debug_wb_rf_wdata = wd;
    tr.ref_valid         = v;
    tr.ref_pc            = e.pc;
    tr.ref_wnum          = e.wnum;
    tr.ref_wdata         = e.wd;
    #1;
    chk("ref_ready", 32'(tr.ref_ready), 32'(rdy));
    evt = run && (we != 0) && (wn != 0);
    msk = bmask(we);
    got = wd & msk;
    if (evt) begin
      m_idle = 0;
      if (q.size() == 0) begin
        set_err(2'b10, pc, 0, got);
      end else begin
        h = q.pop_front();
        if (h.pc == pc && h.wnum == wn && (h.wd & msk) == got) m_cnt++;
        else set_err(2'b01, pc, h.wd, got);
      end
    end else if (run) begin
      m_idle++;
      if (m_idle >= TO) set_err(2'b11, 0, 0, 0);
    end
    if (rdy && v) q.push_back(e);
    if (run && !m_err && pc == ENDPC) m_done = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, mk(0, 0, 0));
  endtask

  task automatic pushc(input ent_t e);
    cyc(0, 0, 0, 0, 1, e);
  endtask

  task automatic com(input logic [31:0] pc, input logic [4:0] wn,
                     input logic [31:0] wd);
    cyc(pc, 4'hf, wn, wd, 0, mk(0, 0, 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    tr.debug_wb_pc = 0;
    tr.debug_wb_rf_we = 0;
    tr.debug_wb_rf_wnum = 0;
    tr.debug_wb_rf_wdata = 0;
    tr.ref_valid = 0;
    tr.ref_pc = 0;
    tr.ref_wnum = 0;
    tr.ref_wdata = 0;
    resetn = 1'b0;
    model_clear();
    #1;
    chk("rst.ready", 32'(tr.ref_ready), 0);
    check_all("rst");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    ent_t        e;
    int          n;
    bit          c;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [31:0] msk;

    model_clear();
    do_reset();

    // prefill three entries then commit them in order
    pushc(mk(32'h1c000000, 5'd4, 32'd5));
    pushc(mk(32'h1c000004, 5'd5, 32'd7));
    pushc(mk(32'h1c000008, 5'd6, 32'd9));
    com(32'h1c000000, 5'd4, 32'd5);
    com(32'h1c000004, 5'd5, 32'd7);
    com(32'h1c000008, 5'd6, 32'd9);
    check_all("t1");
    chk("t1.cnt3", commit_cnt, 32'd3);

    // data mismatch, then later commits must be ignored
    pushc(mk(32'h1c000010, 5'd4, 32'h12345678));
    com(32'h1c000010, 5'd4, 32'h12345679);
    check_all("t2");
    chk("t2.code", 32'(err_code), 32'd1);
    chk("t2.exp", err_exp_wdata, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      com(32'h1c000014, 5'd7, 32'h0);
      check_all("t2.frozen");
    end

    // r0 write is ignored; commit on empty FIFO (with same-cycle push) underflows
    do_reset();
    com(32'h1c000020, 5'd0, 32'h55);
    check_all("t3.r0");
    cyc(32'h1c000020, 4'hf, 5'd3, 32'h55, 1, mk(32'h1c000020, 5'd3, 32'h55));
    check_all("t3.uf");
    chk("t3.code", 32'(err_code), 32'd2);

    // timeout exactly TO cycles after the last commit
    do_reset();
    pushc(mk(32'h1c000030, 5'd9, 32'hdead));
    com(32'h1c000030, 5'd9, 32'hdead);
    n = 0;
    for (int k = 0; k < 30 && !error; k++) begin
      idle();
      n++;
    end
    check_all("t4");
    chk("t4.latency", 32'(n), 32'(TO));
    chk("t4.code", 32'(err_code), 32'd3);

    // fill to DEPTH, then pop/push interplay while at or near full
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pushc(mk(32'h1c000100 + 32'(4 * (i + 1)), 5'(i + 1), $urandom));
    end
    chk("t5.full", 32'(tr.ref_ready), 0);
    com(q[0].pc, q[0].wnum, q[0].wd);
    cyc(q[0].pc, 4'hf, q[0].wnum, q[0].wd, 1, mk(32'h1c000200, 5'd20, $urandom));
    chk("t5.seven", 32'(tr.ref_ready), 1);
    pushc(mk(32'h1c000204, 5'd21, $urandom));
    chk("t5.refull", 32'(tr.ref_ready), 0);
    for (int i = 0; i < DEPTH; i++) begin
      com(q[0].pc, q[0].wnum, q[0].wd);
    end
    check_all("t5.drain");

    // END_PC after two good commits, then async reset mid-run
    do_reset();
    pushc(mk(32'h1c0000f8, 5'd1, 32'h11));
    pushc(mk(32'h1c0000fc, 5'd2, 32'h22));
    com(32'h1c0000f8, 5'd1, 32'h11);
    com(32'h1c0000fc, 5'd2, 32'h22);
    cyc(ENDPC, 0, 0, 0, 0, mk(0, 0, 0));
    check_all("t6");
    chk("t6.done", 32'(done), 1);
    com(32'h1c000104, 5'd3, 32'h0);
    check_all("t6.frozen");
    do_reset();
    pushc(mk(32'h1c000000, 5'd1, 32'h1));
    pushc(mk(32'h1c000004, 5'd2, 32'h2));
    do_reset();
    com(32'h1c000000, 5'd1, 32'h1);
    check_all("t6.empty");

    // random traffic with partial byte enables and masked-off noise
    do_reset();
    for (int i = 0; i < 80; i++) begin
      e = mk($urandom, 5'($urandom_range(1, 31)), $urandom);
      if (e.pc == ENDPC) e.pc = e.pc ^ 32'h1;
      c = (q.size() > 0) && ($urandom_range(0, 3) != 0);
      if (c) begin
        we = 4'($urandom_range(1, 15));
        msk = bmask(we);
        wd = q[0].wd ^ ($urandom & ~msk);
        if (i == 70) wd = wd ^ (msk & 32'h0101_0101);
        cyc(q[0].pc, we, q[0].wnum, wd, 1'($urandom_range(0, 1)), e);
      end else begin
        cyc(0, 4'($urandom_range(0, 15)), 5'd0, $urandom,
            1'($urandom_range(0, 1)), e);
      end
      check_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
